// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
//
// Runs one WIDTH-bit operation through a single 4-bit 74181-compatible slice,
// one nibble per clock, least significant nibble first. The slice carry-out is
// registered and fed back as the next nibble's carry-in, so a WIDTH-bit add
// ripples across NIBBLES clock cycles. WIDTH must be a multiple of 4, >= 4.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid / req_ready      request handshake
//   req_s, req_m, req_cn       74181 select, mode (1 = logic), carry-in (1 = none)
//   req_a, req_b               WIDTH-bit operands
//   alu_s, alu_m, alu_cn,
//   alu_a, alu_b               drive the slice (parked when not running)
//   alu_f, alu_cn_4, alu_a_eq_b slice results, combinational in the same cycle
//   rsp_valid / rsp_ready      response handshake
//   rsp_f, rsp_cout, rsp_eq    result, final carry-out (0 = carry), AND of A=B
module alu_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_s,
    input  logic             req_m,
    input  logic             req_cn,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [3:0]       alu_s,
    output logic             alu_m,
    output logic             alu_cn,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [3:0]       alu_f,
    input  logic             alu_cn_4,
    input  logic             alu_a_eq_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_f,
    output logic             rsp_cout,
    output logic             rsp_eq
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       s_reg;
    logic             m_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] f_reg;
    logic             carry_reg;
    logic             eq_acc;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             last_nibble;

    assign accept      = (state == IDLE) && req_valid;
    assign last_nibble = (idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid)   state_nxt = RUN;
            RUN:     if (last_nibble) state_nxt = DONE;
            DONE:    if (rsp_ready)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from registered state; slice pins parked outside RUN
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == DONE);
        alu_s     = 4'b0000;
        alu_m     = 1'b1;
        alu_cn    = 1'b1;
        alu_a     = 4'h0;
        alu_b     = 4'h0;
        if (state == RUN) begin
            alu_s  = s_reg;
            alu_m  = m_reg;
            alu_cn = carry_reg;
            alu_a  = a_reg[4*int'(idx) +: 4];
            alu_b  = b_reg[4*int'(idx) +: 4];
        end
    end

    // Request capture and per-nibble accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg     <= 4'b0000;
            m_reg     <= 1'b1;
            a_reg     <= '0;
            b_reg     <= '0;
            f_reg     <= '0;
            carry_reg <= 1'b1;
            eq_acc    <= 1'b0;
            idx       <= '0;
        end else if (accept) begin
            s_reg     <= req_s;
            m_reg     <= req_m;
            a_reg     <= req_a;
            b_reg     <= req_b;
            carry_reg <= req_cn;
            eq_acc    <= 1'b1;
            idx       <= '0;
        end else if (state == RUN) begin
            f_reg[4*int'(idx) +: 4] <= alu_f;
            carry_reg <= alu_cn_4;
            eq_acc    <= eq_acc & alu_a_eq_b;
            // Hold idx on the last nibble so it never wraps inside RUN
            if (!last_nibble) begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign rsp_f    = f_reg;
    assign rsp_cout = carry_reg;
    assign rsp_eq   = eq_acc;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
module tb_alu_nibble_sequencer;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [3:0]       req_s = 4'h0;
    logic             req_m = 1'b0;
    logic             req_cn = 1'b1;
    logic [WIDTH-1:0] req_a = '0;
    logic [WIDTH-1:0] req_b = '0;
    logic [3:0]       alu_s;
    logic             alu_m;
    logic             alu_cn;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [3:0]       alu_f;
    logic             alu_cn_4;
    logic             alu_a_eq_b;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_f;
    logic             rsp_cout;
    logic             rsp_eq;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] last_f;
    logic             last_cout;
    logic             last_eq;

    always #5 clk = ~clk;

    alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_s(req_s), .req_m(req_m), .req_cn(req_cn),
        .req_a(req_a), .req_b(req_b),
        .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_f(alu_f), .alu_cn_4(alu_cn_4), .alu_a_eq_b(alu_a_eq_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_f(rsp_f), .rsp_cout(rsp_cout), .rsp_eq(rsp_eq)
    );

    // 74181 active-high logic-mode functions, bitwise over any width
    function automatic logic [WIDTH-1:0] logic_fn(input logic [3:0] s,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (s)
            4'd0:    return ~a;
            4'd1:    return ~(a | b);
            4'd2:    return ~a & b;
            4'd3:    return '0;
            4'd4:    return ~(a & b);
            4'd5:    return ~b;
            4'd6:    return a ^ b;
            4'd7:    return a & ~b;
            4'd8:    return ~a | b;
            4'd9:    return ~(a ^ b);
            4'd10:   return b;
            4'd11:   return a & b;
            4'd12:   return '1;
            4'd13:   return a | ~b;
            4'd14:   return a | b;
            default: return a;
        endcase
    endfunction

    // Behavioural 4-bit slice: arithmetic result is X plus Y plus carry
    logic [3:0]       sl_x;
    logic [3:0]       sl_y;
    logic [4:0]       sl_sum;
    logic [WIDTH-1:0] sl_lf;
    always_comb begin
        sl_x   = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
        sl_y   = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
        sl_sum = {1'b0, sl_x} + {1'b0, sl_y} + {4'b0, ~alu_cn};
        sl_lf  = logic_fn(alu_s, {{(WIDTH-4){1'b0}}, alu_a}, {{(WIDTH-4){1'b0}}, alu_b});
        alu_f  = alu_m ? sl_lf[3:0] : sl_sum[3:0];
        alu_cn_4   = ~sl_sum[4];
        alu_a_eq_b = &alu_f;
    end

    // Full-width reference: one wide addition instead of nibble chaining
    task automatic ref_op(input logic [3:0] s, input logic m, input logic cn,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output logic [WIDTH-1:0] f, output logic co, output logic eq,
                          output logic [NIB-1:0] cn_pins);
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        longint unsigned  xl, yl, c0, sum, mask, sk;
        x  = a | (b & {WIDTH{s[0]}}) | (~b & {WIDTH{s[1]}});
        y  = (a & ~b & {WIDTH{s[2]}}) | (a & b & {WIDTH{s[3]}});
        xl = longint'(x);
        yl = longint'(y);
        c0 = cn ? 0 : 1;
        sum = xl + yl + c0;
        f  = m ? logic_fn(s, a, b) : sum[WIDTH-1:0];
        co = ~sum[WIDTH];
        eq = &f;
        for (int k = 0; k < NIB; k++) begin
            mask = (64'd1 << (4 * k)) - 64'd1;
            sk   = (xl & mask) + (yl & mask) + c0;
            cn_pins[k] = ~sk[4 * k];
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_parked(input string tag);
        check({tag, "_alu_a"}, 32'(alu_a), 32'h0);
        check({tag, "_alu_b"}, 32'(alu_b), 32'h0);
        check({tag, "_alu_s"}, 32'(alu_s), 32'h0);
        check({tag, "_alu_m"}, 32'(alu_m), 32'h1);
        check({tag, "_alu_cn"}, 32'(alu_cn), 32'h1);
    endtask

    // Called at a negedge with the DUT idle. hold = cycles of rsp_ready low in
    // DONE; when bp is set, a further request is presented during the hold.
    task automatic run_op(input logic [3:0] s, input logic m, input logic cn,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int hold, input logic bp,
                          input logic [WIDTH-1:0] nxt_a, input logic [WIDTH-1:0] nxt_b);
        logic [WIDTH-1:0] ef;
        logic             ec, ee;
        logic [NIB-1:0]   ecn;
        int               waited;
        ref_op(s, m, cn, a, b, ef, ec, ee, ecn);
        check("ready_before_accept", 32'(req_ready), 32'h1);
        req_s = s; req_m = m; req_cn = cn; req_a = a; req_b = b;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_a = WIDTH'($urandom);
        req_b = WIDTH'($urandom);
        req_s = 4'($urandom);
        req_cn = ~cn;
        for (int k = 0; k < NIB; k++) begin
            check("run_alu_a", 32'(alu_a), 32'(a[4*k +: 4]));
            check("run_alu_b", 32'(alu_b), 32'(b[4*k +: 4]));
            check("run_alu_s", 32'(alu_s), 32'(s));
            check("run_alu_m", 32'(alu_m), 32'(m));
            check("run_alu_cn", 32'(alu_cn), 32'(ecn[k]));
            check("run_rsp_valid", 32'(rsp_valid), 32'h0);
            check("run_req_ready", 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        check("rsp_valid_arrival", 32'(rsp_valid), 32'h1);
        check("rsp_f", 32'(rsp_f), 32'(ef));
        check("rsp_cout", 32'(rsp_cout), 32'(ec));
        check("rsp_eq", 32'(rsp_eq), 32'(ee));
        check_parked("done");
        last_f = rsp_f; last_cout = rsp_cout; last_eq = rsp_eq;
        if (bp) begin
            req_s = 4'b1001; req_m = 1'b0; req_cn = 1'b1;
            req_a = nxt_a; req_b = nxt_b;
            req_valid = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'h1);
            check("hold_rsp_f", 32'(rsp_f), 32'(ef));
            check("hold_rsp_cout", 32'(rsp_cout), 32'(ec));
            check("hold_rsp_eq", 32'(rsp_eq), 32'(ee));
            check("hold_req_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        waited = 0;
        while (!req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("idle_after_rsp_delay", 32'(waited), 32'h0);
        check("idle_after_rsp_valid", 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]       rs;
        logic             rm, rc;
        logic [WIDTH-1:0] ra, rb;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_f", 32'(rsp_f), 32'h0);
        check("rst_rsp_cout", 32'(rsp_cout), 32'h1);
        check("rst_rsp_eq", 32'(rsp_eq), 32'h0);
        check_parked("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h1);

        // Add with nibble sequence on alu_a = 4,3,2,1
        run_op(4'b1001, 1'b0, 1'b1, 16'h1234, 16'h0FFF, 0, 1'b0, '0, '0);
        check("add_f_const", 32'(last_f), 32'h2233);
        check("add_cout_const", 32'(last_cout), 32'h1);

        // Carry ripple through every nibble
        run_op(4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 0, 1'b0, '0, '0);
        check("ripple_f_const", 32'(last_f), 32'h0000);
        check("ripple_cout_const", 32'(last_cout), 32'h0);

        // Compare, equal and unequal
        run_op(4'b0110, 1'b0, 1'b1, 16'h5A5A, 16'h5A5A, 0, 1'b0, '0, '0);
        check("cmp_eq_f_const", 32'(last_f), 32'hFFFF);
        check("cmp_eq_const", 32'(last_eq), 32'h1);
        run_op(4'b0110, 1'b0, 1'b1, 16'h5A5A, 16'h5A5B, 0, 1'b0, '0, '0);
        check("cmp_ne_const", 32'(last_eq), 32'h0);

        // Logic XOR
        run_op(4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, 0, 1'b0, '0, '0);
        check("xor_f_const", 32'(last_f), 32'h0FF0);

        // Backpressure with a queued request, accepted one cycle after handshake
        run_op(4'b1001, 1'b0, 1'b0, 16'h00FF, 16'h0F01, 3, 1'b1, 16'h0101, 16'h0202);
        run_op(4'b1001, 1'b0, 1'b1, 16'h0101, 16'h0202, 0, 1'b0, '0, '0);
        check("bp_second_f_const", 32'(last_f), 32'h0303);

        // Reset during the nibble-2 RUN cycle
        req_s = 4'b1001; req_m = 1'b0; req_cn = 1'b1;
        req_a = 16'h1111; req_b = 16'h2222;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_nibble2_alu_a", 32'(alu_a), 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        check("abort_rsp_f", 32'(rsp_f), 32'h0);
        check("abort_rsp_cout", 32'(rsp_cout), 32'h1);
        check("abort_rsp_eq", 32'(rsp_eq), 32'h0);
        check_parked("abort");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(rsp_valid), 32'h0);
            check("abort_req_ready", 32'(req_ready), 32'h1);
        end
        run_op(4'b1001, 1'b0, 1'b1, 16'h1234, 16'h0FFF, 0, 1'b0, '0, '0);
        check("post_abort_add_const", 32'(last_f), 32'h2233);

        // Randomized operations with random response backpressure
        for (int n = 0; n < 40; n++) begin
            rs = 4'($urandom);
            rm = 1'($urandom);
            rc = 1'($urandom);
            ra = WIDTH'($urandom);
            rb = (n % 5 == 0) ? ra : WIDTH'($urandom);
            run_op(rs, rm, rc, ra, rb, int'($urandom_range(0, 2)), 1'b0, '0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
